// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard command sequencer: sends a command (plus optional argument) through
// ps2_port, handles ACK/RESEND/timeout retries, and buffers scan codes in a FIFO.
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned MAX_RETRY       = 3,
  parameter int unsigned RESP_TIMEOUT_US = 20000
) (
  input  logic       clk6x,
  input  logic       reset,
  input  logic       ck1us,
  input  logic [7:0] cmd_i,
  input  logic [7:0] arg_i,
  input  logic       has_arg_i,
  input  logic       cmd_v_i,
  output logic       cmd_busy_o,
  output logic       cmd_done_o,
  output logic       cmd_err_o,
  output logic [7:0] resp_o,
  output logic [7:0] kbd_code_o,
  output logic       kbd_code_v_o,
  input  logic       kbd_code_rd_i,
  output logic       fifo_ovf_o,
  input  logic       ovf_clr_i,
  output logic [7:0] port_tx_o,
  output logic       port_tx_v_o,
  input  logic       port_busy_i,
  input  logic       port_acked_i,
  input  logic       port_errd_i,
  input  logic [7:0] port_rx_code_i,
  input  logic       port_rx_v_i
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam int unsigned RW      = ($clog2(MAX_RETRY + 1) > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned TW      = $clog2(RESP_TIMEOUT_US + 1);
  localparam logic [7:0]  CodeAck = 8'hFA;
  localparam logic [7:0]  CodeRes = 8'hFE;

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitTx,
    StWaitResp,
    StDone,
    StErr
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    arg_q, arg_d;
  logic          has_arg_q, has_arg_d;
  logic          byte_sel_q, byte_sel_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    tx_q, tx_d;
  logic          tx_v_q, tx_v_d;
  logic [7:0]    resp_q, resp_d;
  logic          retry_req;
  logic [7:0]    cur_byte;

  // FIFO storage and control
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] fifo_cnt;
  logic        ovf_q, ovf_d;
  logic        fifo_full, fifo_empty;
  logic        rx_is_resp, push, pop, push_ok;

  assign cur_byte = byte_sel_q ? arg_q : cmd_q;

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    has_arg_d  = has_arg_q;
    byte_sel_d = byte_sel_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    tx_d       = tx_q;
    tx_v_d     = 1'b0;
    resp_d     = resp_q;
    retry_req  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_v_i) begin
          cmd_d      = cmd_i;
          arg_d      = arg_i;
          has_arg_d  = has_arg_i;
          byte_sel_d = 1'b0;
          retry_d    = '0;
          state_d    = StSend;
        end
      end
      StSend: begin
        if (!port_busy_i) begin
          tx_d    = cur_byte;
          tx_v_d  = 1'b1;
          state_d = StWaitTx;
        end
      end
      StWaitTx: begin
        if (port_rx_v_i) resp_d = port_rx_code_i;
        if (port_acked_i) begin
          timer_d = '0;
          state_d = StWaitResp;
        end else if (port_errd_i) begin
          retry_req = 1'b1;
        end
      end
      StWaitResp: begin
        if (port_rx_v_i) resp_d = port_rx_code_i;
        if (port_rx_v_i && port_rx_code_i == CodeAck) begin
          if (!byte_sel_q && has_arg_q) begin
            byte_sel_d = 1'b1;
            retry_d    = '0;
            state_d    = StSend;
          end else begin
            state_d = StDone;
          end
        end else if (port_rx_v_i && port_rx_code_i == CodeRes) begin
          retry_req = 1'b1;
        end else if (timer_q == TW'(RESP_TIMEOUT_US)) begin
          retry_req = 1'b1;
        end else if (ck1us) begin
          timer_d = timer_q + TW'(1);
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Resend the same byte until the retry budget is spent
    if (retry_req) begin
      if (retry_q < RW'(MAX_RETRY)) begin
        retry_d = retry_q + RW'(1);
        state_d = StSend;
      end else begin
        state_d = StErr;
      end
    end
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      arg_q      <= '0;
      has_arg_q  <= 1'b0;
      byte_sel_q <= 1'b0;
      retry_q    <= '0;
      timer_q    <= '0;
      tx_q       <= '0;
      tx_v_q     <= 1'b0;
      resp_q     <= '0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      has_arg_q  <= has_arg_d;
      byte_sel_q <= byte_sel_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      tx_q       <= tx_d;
      tx_v_q     <= tx_v_d;
      resp_q     <= resp_d;
    end
  end

  assign cmd_busy_o  = (state_q == StSend) || (state_q == StWaitTx) || (state_q == StWaitResp);
  assign cmd_done_o  = (state_q == StDone);
  assign cmd_err_o   = (state_q == StErr);
  assign resp_o      = resp_q;
  assign port_tx_o   = tx_q;
  assign port_tx_v_o = tx_v_q;

  // ACK/RESEND answering a pending byte are consumed by the sequencer
  assign rx_is_resp = (state_q == StWaitResp) &&
                      (port_rx_code_i == CodeAck || port_rx_code_i == CodeRes);

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_full  = (fifo_cnt == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push       = port_rx_v_i && !rx_is_resp;
  assign pop        = kbd_code_rd_i && !fifo_empty;
  assign push_ok    = push && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW + 1)'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + (AW + 1)'(1);
    // A new drop wins over a clear in the same cycle
    if (push && !push_ok) begin
      ovf_d = 1'b1;
    end else if (ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk6x) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk6x) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= port_rx_code_i;
  end

  assign kbd_code_o   = mem_q[rd_ptr_q[AW-1:0]];
  assign kbd_code_v_o = !fifo_empty;
  assign fifo_ovf_o   = ovf_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: command/retry/timeout sequences and FIFO boundaries.
module tb_ps2_kbd_ctrl;

  localparam int unsigned Timeout = 1000;

  logic       clk6x = 1'b0;
  logic       reset = 1'b1;
  logic       ck1us = 1'b0;
  logic [7:0] cmd_i = '0;
  logic [7:0] arg_i = '0;
  logic       has_arg_i = 1'b0;
  logic       cmd_v_i = 1'b0;
  logic       cmd_busy_o, cmd_done_o, cmd_err_o;
  logic [7:0] resp_o, kbd_code_o, port_tx_o;
  logic       kbd_code_v_o, fifo_ovf_o, port_tx_v_o;
  logic       kbd_code_rd_i = 1'b0;
  logic       ovf_clr_i = 1'b0;
  logic       port_busy_i = 1'b0;
  logic       port_acked_i = 1'b0;
  logic       port_errd_i = 1'b0;
  logic [7:0] port_rx_code_i = '0;
  logic       port_rx_v_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int tx_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  ps2_kbd_ctrl #(
    .FIFO_DEPTH     (16),
    .MAX_RETRY      (3),
    .RESP_TIMEOUT_US(Timeout)
  ) dut (
    .clk6x         (clk6x),
    .reset         (reset),
    .ck1us         (ck1us),
    .cmd_i         (cmd_i),
    .arg_i         (arg_i),
    .has_arg_i     (has_arg_i),
    .cmd_v_i       (cmd_v_i),
    .cmd_busy_o    (cmd_busy_o),
    .cmd_done_o    (cmd_done_o),
    .cmd_err_o     (cmd_err_o),
    .resp_o        (resp_o),
    .kbd_code_o    (kbd_code_o),
    .kbd_code_v_o  (kbd_code_v_o),
    .kbd_code_rd_i (kbd_code_rd_i),
    .fifo_ovf_o    (fifo_ovf_o),
    .ovf_clr_i     (ovf_clr_i),
    .port_tx_o     (port_tx_o),
    .port_tx_v_o   (port_tx_v_o),
    .port_busy_i   (port_busy_i),
    .port_acked_i  (port_acked_i),
    .port_errd_i   (port_errd_i),
    .port_rx_code_i(port_rx_code_i),
    .port_rx_v_i   (port_rx_v_i)
  );

  always #5 clk6x = ~clk6x;

  always @(negedge clk6x) begin
    if (port_tx_v_o) tx_cnt++;
    if (cmd_done_o)  done_cnt++;
    if (cmd_err_o)   err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk6x);
      #1;
    end
  endtask

  task automatic start_cmd(input logic [7:0] c, input logic [7:0] a, input logic h);
    cmd_i = c; arg_i = a; has_arg_i = h; cmd_v_i = 1'b1;
    tick();
    cmd_v_i = 1'b0;
  endtask

  task automatic rx(input logic [7:0] code);
    port_rx_code_i = code; port_rx_v_i = 1'b1;
    tick();
    port_rx_v_i = 1'b0;
  endtask

  task automatic ack_line();
    port_acked_i = 1'b1;
    tick();
    port_acked_i = 1'b0;
  endtask

  task automatic wait_strobe(input string tag, input logic [7:0] exp_byte);
    int n = 0;
    tick();
    while (!port_tx_v_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_strobe"}, port_tx_v_o, 1);
    check({tag, "_byte"}, port_tx_o, exp_byte);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (cmd_busy_o && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, cmd_busy_o, 0);
    tick();
  endtask

  initial begin
    int tx0, done0, err0, k;
    logic [7:0] code;

    tick(3);
    reset = 1'b0;
    check("rst_busy", cmd_busy_o, 0);
    check("rst_done", cmd_done_o, 0);
    check("rst_err", cmd_err_o, 0);
    check("rst_resp", resp_o, 8'h00);
    check("rst_txv", port_tx_v_o, 0);
    check("rst_tx", port_tx_o, 8'h00);
    check("rst_fifo_v", kbd_code_v_o, 0);
    check("rst_ovf", fifo_ovf_o, 0);

    // FF, no argument: two-cycle latency to the strobe, single done pulse
    done0 = done_cnt;
    start_cmd(8'hFF, 8'h00, 1'b0);
    check("ff_busy", cmd_busy_o, 1);
    check("ff_txv_early", port_tx_v_o, 0);
    tick();
    check("ff_txv", port_tx_v_o, 1);
    check("ff_tx", port_tx_o, 8'hFF);
    tick();
    ack_line();
    rx(8'hFA);
    check("ff_done", cmd_done_o, 1);
    check("ff_busy_drop", cmd_busy_o, 0);
    tick();
    check("ff_done_once", done_cnt - done0, 1);
    check("ff_resp", resp_o, 8'hFA);
    check("ff_fifo_empty", kbd_code_v_o, 0);

    // ED 07: cmd FA, arg FE then FA
    tx0 = tx_cnt; done0 = done_cnt; err0 = err_cnt;
    start_cmd(8'hED, 8'h07, 1'b1);
    wait_strobe("ed0", 8'hED); ack_line(); rx(8'hFA);
    wait_strobe("ed1", 8'h07); ack_line(); rx(8'hFE);
    wait_strobe("ed2", 8'h07); ack_line(); rx(8'hFA);
    wait_idle("ed");
    check("ed_tx_count", tx_cnt - tx0, 3);
    check("ed_done", done_cnt - done0, 1);
    check("ed_err", err_cnt - err0, 0);

    // F4 with port busy first, then four RESENDs exhaust the retries
    tx0 = tx_cnt; done0 = done_cnt; err0 = err_cnt;
    port_busy_i = 1'b1;
    start_cmd(8'hF4, 8'h00, 1'b0);
    tick(5);
    check("busy_hold_tx", tx_cnt - tx0, 0);
    port_busy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_strobe("fe", 8'hF4); ack_line(); rx(8'hFE);
    end
    check("fe_err_now", cmd_err_o, 1);
    wait_idle("fe");
    check("fe_tx_count", tx_cnt - tx0, 4);
    check("fe_err", err_cnt - err0, 1);
    check("fe_done", done_cnt - done0, 0);
    check("fe_resp", resp_o, 8'hFE);

    // F4 with no reply: each timeout consumes exactly Timeout pulses
    tx0 = tx_cnt; err0 = err_cnt;
    start_cmd(8'hF4, 8'h00, 1'b0);
    wait_strobe("to", 8'hF4);
    for (int i = 0; i < 4; i++) begin
      ack_line();
      ck1us = 1'b1;
      k = 0;
      while (!port_tx_v_o && !cmd_err_o && k < Timeout + 10) begin
        tick();
        k++;
      end
      ck1us = 1'b0;
      check("to_edges", k, (i < 3) ? Timeout + 2 : Timeout + 1);
    end
    check("to_err_now", cmd_err_o, 1);
    wait_idle("to");
    check("to_tx_count", tx_cnt - tx0, 4);
    check("to_err", err_cnt - err0, 1);

    // 17 codes into a 16-deep FIFO while idle
    for (int i = 0; i < 17; i++) rx(8'h1C + 8'(i));
    check("ovf_set", fifo_ovf_o, 1);
    check("full_head", kbd_code_o, 8'h1C);
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    check("ovf_clr", fifo_ovf_o, 0);
    kbd_code_rd_i = 1'b1; rx(8'h3D); kbd_code_rd_i = 1'b0;
    check("pop_push_ovf", fifo_ovf_o, 0);
    ovf_clr_i = 1'b1; rx(8'h3E); ovf_clr_i = 1'b0;
    check("ovf_beats_clr", fifo_ovf_o, 1);
    for (int i = 0; i < 16; i++) begin
      code = (i < 15) ? 8'h1D + 8'(i) : 8'h3D;
      check("fifo_v", kbd_code_v_o, 1);
      check("fifo_order", kbd_code_o, code);
      kbd_code_rd_i = 1'b1; tick(); kbd_code_rd_i = 1'b0;
    end
    check("fifo_drained", kbd_code_v_o, 0);
    kbd_code_rd_i = 1'b1; tick(); kbd_code_rd_i = 1'b0;
    check("pop_empty", kbd_code_v_o, 0);

    // Scan code mid-command is buffered, FA is not
    done0 = done_cnt;
    start_cmd(8'hF4, 8'h00, 1'b0);
    wait_strobe("mid", 8'hF4); ack_line();
    rx(8'h1C); rx(8'hFA);
    wait_idle("mid");
    check("mid_done", done_cnt - done0, 1);
    check("mid_resp", resp_o, 8'hFA);
    check("mid_fifo_v", kbd_code_v_o, 1);
    check("mid_fifo_code", kbd_code_o, 8'h1C);
    kbd_code_rd_i = 1'b1; tick(); kbd_code_rd_i = 1'b0;
    check("mid_fifo_fa_absent", kbd_code_v_o, 0);

    // Reset while waiting for the response
    done0 = done_cnt; err0 = err_cnt;
    start_cmd(8'hF4, 8'h00, 1'b0);
    wait_strobe("rstw", 8'hF4); ack_line(); rx(8'h33);
    reset = 1'b1; tick(); reset = 1'b0;
    check("rstw_busy", cmd_busy_o, 0);
    check("rstw_fifo", kbd_code_v_o, 0);
    tick(3);
    check("rstw_txv", port_tx_v_o, 0);
    check("rstw_done", done_cnt - done0, 0);
    check("rstw_err", err_cnt - err0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
